// File: rtl/reg_file_param.sv
// reg_file_param: flop-based register file with one write port, two combinational read
// ports, a one-entry-per-cycle clear sweep and a registered write-error pulse.
// Optional macro RF_BYPASS_EN: an accepted write is forwarded to reads of the same index.
module reg_file_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeEn,
  input  logic [AW-1:0]    writeReg,
  input  logic [WIDTH-1:0] writeData,
  input  logic [AW-1:0]    read1Reg,
  input  logic [AW-1:0]    read2Reg,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  input  logic             clrReq,
  output logic             busy,
  output logic             err
);

  // Request semantics: writeEn and clrReq are sampled at every rising edge with no
  // back-pressure. A write that cannot be taken (sweep running or index out of range)
  // is dropped and flagged on err for the following cycle; clrReq is honoured only in IDLE.
  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH-1);

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_ptr;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_wr_idx_ok;
  logic w_wr_ok;
  logic w_wr_rej;

  assign w_wr_idx_ok = ({1'b0, writeReg} < LP_DEPTH);
  assign w_wr_ok     = writeEn && (r_state == S_IDLE) && w_wr_idx_ok;
  assign w_wr_rej    = writeEn && !w_wr_ok;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (clrReq) w_next_state = S_SWEEP;
      S_SWEEP: if (r_ptr == LP_LAST) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The pointer rests at 0 in IDLE so a new sweep always starts from entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_wr_rej;
      if ((r_state == S_SWEEP) && (r_ptr != LP_LAST)) r_ptr <= r_ptr + AW'(1);
      else                                            r_ptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_SWEEP) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[writeReg] <= writeData;
    end
  end

  always_comb begin
    read1Data = '0;
    if ({1'b0, read1Reg} < LP_DEPTH) read1Data = r_mem[read1Reg];
`ifdef RF_BYPASS_EN
    if (w_wr_ok && (read1Reg == writeReg)) read1Data = writeData;
`endif
  end

  always_comb begin
    read2Data = '0;
    if ({1'b0, read2Reg} < LP_DEPTH) read2Data = r_mem[read2Reg];
`ifdef RF_BYPASS_EN
    if (w_wr_ok && (read2Reg == writeReg)) read2Data = writeData;
`endif
  end

  assign busy = (r_state == S_SWEEP);
  assign err  = r_err;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed scenarios plus random traffic on an 8-entry instance,
// checked against an array/countdown model; a 6-entry instance covers out-of-range indices.
`timescale 1ns/1ps
module tb_reg_file_param;
  localparam int WIDTH = 16;
  localparam int D8    = 8;
  localparam int D6    = 6;
  localparam int AW    = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             we, clr, busy, err;
  logic [AW-1:0]    wr, r1, r2;
  logic [WIDTH-1:0] wd, rd1, rd2;

  logic             we6, clr6, busy6, err6;
  logic [AW-1:0]    wr6, r16, r26;
  logic [WIDTH-1:0] wd6, rd16, rd26;

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(D8)) u_dut8 (
    .clk(clk), .rst(rst), .writeEn(we), .writeReg(wr), .writeData(wd),
    .read1Reg(r1), .read2Reg(r2), .read1Data(rd1), .read2Data(rd2),
    .clrReq(clr), .busy(busy), .err(err)
  );

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(D6)) u_dut6 (
    .clk(clk), .rst(rst), .writeEn(we6), .writeReg(wr6), .writeData(wd6),
    .read1Reg(r16), .read2Reg(r26), .read1Data(rd16), .read2Data(rd26),
    .clrReq(clr6), .busy(busy6), .err(err6)
  );

  // scoreboard / reference model
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] mem [D8];
  int               sweep_cnt;
  logic             exp_err;
  logic [WIDTH-1:0] exp_q[$];
  int               busy_cycles;
  int               guard;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_read(input int idx);
    if (idx >= D8) return '0;
`ifdef RF_BYPASS_EN
    if (we && (sweep_cnt == 0) && (int'(wr) == idx)) return wd;
`endif
    return mem[idx];
  endfunction

  // Sweep modelled as a countdown of remaining entries; clears go in ascending index order.
  task automatic model_edge();
    exp_err = we && ((sweep_cnt > 0) || (int'(wr) >= D8));
    if (sweep_cnt > 0) begin
      mem[D8 - sweep_cnt] = '0;
      sweep_cnt--;
    end else begin
      if (we && (int'(wr) < D8)) mem[wr] = wd;
      if (clr) sweep_cnt = D8;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D8; i++) mem[i] = '0;
    sweep_cnt = 0;
    exp_err   = 1'b0;
  endtask

  // driver tasks
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".busy"}, busy, sweep_cnt > 0);
    check({tag, ".err"}, err, exp_err);
  endtask

  task automatic check_rd(input string tag);
    #0.2;
    check({tag, ".rd1"}, rd1, exp_read(int'(r1)));
    check({tag, ".rd2"}, rd2, exp_read(int'(r2)));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < D8; i++) begin
      r1 = AW'(i);
      r2 = AW'(D8 - 1 - i);
      check_rd(tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    we = 0; clr = 0; wr = '0; wd = '0; r1 = '0; r2 = '0;
    we6 = 0; clr6 = 0; wr6 = '0; wd6 = '0; r16 = '0; r26 = '0;
    model_reset();

    // 1: reset state
    #12;
    check("t1.busy", busy, 1'b0);
    check("t1.err", err, 1'b0);
    check("t1.busy6", busy6, 1'b0);
    read_all("t1");
    @(negedge clk);
    rst = 1'b1;
    cycle("t1.idle");

    // 2: single write, both ports on the same entry
    we = 1; wr = 3'd3; wd = 16'hBEEF;
    cycle("t2.wr");
    we = 0; r1 = 3'd3; r2 = 3'd3;
    #0.2;
    check("t2.rd1", rd1, 16'hBEEF);
    check("t2.rd2", rd2, 16'hBEEF);
    read_all("t2");

    // 3: same-cycle read of the entry being written
    we = 1; wr = 3'd5; wd = 16'h1234; r1 = 3'd5; r2 = 3'd3;
    check_rd("t3.same");
`ifdef RF_BYPASS_EN
    check("t3.fwd", rd1, 16'h1234);
`else
    check("t3.nofwd", rd1, 16'h0000);
`endif
    cycle("t3.wr");
    we = 0;
    #0.2;
    check("t3.next", rd1, 16'h1234);

    // 4: fill then sweep
    for (int k = 0; k < D8; k++) begin
      we = 1; wr = AW'(k); wd = 16'h00AA + WIDTH'(k);
      exp_q.push_back(16'h00AA + WIDTH'(k));
      cycle("t4.fill");
    end
    we = 0;
    for (int k = 0; k < D8; k++) begin
      r1 = AW'(k);
      #0.2;
      check("t4.fillrd", rd1, exp_q.pop_front());
    end
    clr = 1;
    cycle("t4.acc");
    clr = 0;
    busy_cycles = 0;
    guard = 0;
    while (busy && (guard < 20)) begin
      if (busy_cycles < D8) begin
        r2 = AW'(busy_cycles);
        #0.2;
        check("t4.notyet", rd2, 16'h00AA + WIDTH'(busy_cycles));
      end
      if (busy_cycles > 0) begin
        r1 = AW'(busy_cycles - 1);
        #0.2;
        check("t4.cleared", rd1, 16'h0000);
      end
      read_all("t4.sweep");
      busy_cycles++;
      guard++;
      cycle("t4.sweep");
    end
    check("t4.busylen", busy_cycles, D8);
    read_all("t4.after");

    // 5: write rejected during a sweep
    we = 1; wr = 3'd2; wd = 16'h2222;
    cycle("t5.pre");
    we = 0;
    clr = 1;
    cycle("t5.acc");
    clr = 0;
    cycle("t5.s1");
    we = 1; wr = 3'd2; wd = 16'hFFFF;
    cycle("t5.rej");
    check("t5.errpulse", err, 1'b1);
    we = 0;
    cycle("t5.after");
    check("t5.errlow", err, 1'b0);
    guard = 0;
    while ((sweep_cnt > 0) && (guard < 20)) begin
      guard++;
      cycle("t5.drain");
    end
    r1 = 3'd2;
    #0.2;
    check("t5.ent2", rd1, 16'h0000);

    // simultaneous write and clear in IDLE
    we = 1; wr = 3'd6; wd = 16'h6666; clr = 1; r1 = 3'd6;
    check_rd("t5.both.same");
    cycle("t5.both");
    we = 0; clr = 0;
    #0.2;
    check("t5.both.written", rd1, 16'h6666);
    guard = 0;
    while ((sweep_cnt > 0) && (guard < 20)) begin
      guard++;
      check_rd("t5.both.sweep");
      cycle("t5.both.sweep");
    end
    #0.2;
    check("t5.both.zeroed", rd1, 16'h0000);

    // 5b: 6-entry instance, out-of-range index
    we6 = 1; wr6 = 3'd5; wd6 = 16'h5555;
    cycle("t5b.wr5");
    check("t5b.err0", err6, 1'b0);
    we6 = 1; wr6 = 3'd7; wd6 = 16'h7777;
    cycle("t5b.wr7");
    check("t5b.errpulse", err6, 1'b1);
    we6 = 0;
    cycle("t5b.after");
    check("t5b.errlow", err6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r16 = AW'(i);
      r26 = AW'(7 - i);
      #0.2;
      check("t5b.rd1", rd16, (i == 5) ? 16'h5555 : 16'h0000);
      check("t5b.rd2", rd26, ((7 - i) == 5) ? 16'h5555 : 16'h0000);
    end
    clr6 = 1;
    cycle("t5b.acc");
    clr6 = 0;
    busy_cycles = 0;
    guard = 0;
    while (busy6 && (guard < 20)) begin
      busy_cycles++;
      guard++;
      cycle("t5b.sweep");
    end
    check("t5b.busylen", busy_cycles, D6);
    r26 = 3'd5;
    #0.2;
    check("t5b.ent5", rd26, 16'h0000);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      we  = ($urandom_range(0, 1) == 1);
      wr  = AW'($urandom_range(0, D8 - 1));
      wd  = WIDTH'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      r1  = AW'($urandom_range(0, D8 - 1));
      r2  = AW'($urandom_range(0, D8 - 1));
      check_rd("rand");
      cycle("rand");
    end
    we = 0; clr = 0;
    guard = 0;
    while ((sweep_cnt > 0) && (guard < 20)) begin
      guard++;
      cycle("rand.drain");
    end
    read_all("rand.end");

    // 6: asynchronous reset in the middle of a sweep
    for (int k = 0; k < D8; k++) begin
      we = 1; wr = AW'(k); wd = WIDTH'($urandom_range(1, 16'hFFFF));
      cycle("t6.fill");
    end
    we = 0;
    clr = 1;
    cycle("t6.acc");
    clr = 0;
    cycle("t6.s1");
    #2;
    rst = 1'b0;
    model_reset();
    #0.5;
    check("t6.busy", busy, 1'b0);
    check("t6.err", err, 1'b0);
    read_all("t6.rst");
    rst = 1'b1;
    we = 1; wr = 3'd4; wd = 16'hABCD;
    cycle("t6.wr");
    we = 0; r1 = 3'd4;
    #0.2;
    check("t6.rd", rd1, 16'hABCD);
    read_all("t6.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
